// File: rtl/vector_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sweep_ctrl
//  Description : Exhaustive input-sweep sequencer for a benchmark DUT. It
//                drives every vector 0 .. 2^N_W-1 in ascending order on N,
//                waits SETTLE extra cycles, samples dut_out and emits one
//                {vector, response} record per vector over a valid/ready
//                stream. Optional response signature is enabled by defining
//                the macro SWEEP_SIG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_sweep_ctrl #(
  parameter int N_W    = 3,   // DUT input width; sweep covers 2^N_W vectors
  parameter int OUT_W  = 1,   // DUT output width, 1..16
  parameter int SETTLE = 1    // extra settle cycles before sampling, 0..255
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   N,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_W-1:0]   rec_vec,
  output logic [OUT_W-1:0] rec_out,
  output logic [N_W:0]     rec_count
`ifdef SWEEP_SIG_EN
  ,
  output logic [15:0]      sig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EMIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]     C_SETTLE = 8'(SETTLE);
  localparam logic [N_W-1:0] C_LAST   = {N_W{1'b1}};
  // Largest record count: one record per vector, so 2^N_W.
  localparam logic [N_W:0]   C_MAX    = {1'b1, {N_W{1'b0}}};

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [N_W-1:0]     vec_q, vec_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [N_W:0]       count_q, count_d;
  logic               w_hs;

`ifdef SWEEP_SIG_EN
  logic [15:0]        sig_q, sig_d;
`endif

  // A record is consumed only when one is actually being offered.
  assign w_hs = vld_q && rec_ready;

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    vec_d   = vec_q;
    out_d   = out_q;
    count_d = count_q;
`ifdef SWEEP_SIG_EN
    sig_d   = sig_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = '0;
          count_d = '0;
          cnt_d   = C_SETTLE;
`ifdef SWEEP_SIG_EN
          sig_d   = '0;
`endif
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Vector has been on N for SETTLE+1 cycles: capture the response.
          out_d   = dut_out;
          vec_d   = n_q;
          vld_d   = 1'b1;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        // Record and N are held untouched until the consumer takes it.
        if (w_hs) begin
          vld_d = 1'b0;
          if (count_q != C_MAX) begin
            count_d = count_q + 1'b1;
          end
`ifdef SWEEP_SIG_EN
          sig_d = {sig_q[14:0], sig_q[15]} ^ 16'(out_q);
`endif
          if (n_q == C_LAST) begin
            // Last vector stays on N; the sweep never wraps.
            state_d = S_DONE;
          end else begin
            n_d     = n_q + 1'b1;
            cnt_d   = C_SETTLE;
            state_d = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so an aborted
  // sweep leaves no partial record behind.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      vec_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      vec_q   <= vec_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

`ifdef SWEEP_SIG_EN
  // Response signature register, held after DONE until the next start.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

  // busy covers SETTLE, EMIT and DONE; done is the single DONE cycle.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign N         = n_q;
  assign rec_valid = vld_q;
  assign rec_vec   = vec_q;
  assign rec_out   = out_q;
  assign rec_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_vector_sweep_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic reset;
  logic start_drv;
  logic ready_drv;
  int   sel;     // 1: instance with SETTLE=1, 0: instance with SETTLE=0
  int   mode1;   // dut_out source for SETTLE=1 instance: 0 comb, 1 lagged, 2 const 1

  // SETTLE=1 instance
  logic       busy1, done1, valid1;
  logic [2:0] n1, vec1;
  logic       out1, dout1;
  logic [3:0] cnt1;
  // SETTLE=0 instance
  logic       busy0, done0, valid0;
  logic [2:0] n0, vec0;
  logic       out0, dout0;
  logic [3:0] cnt0;
`ifdef SWEEP_SIG_EN
  logic [15:0] sig1, sig0;
`endif

  logic st1, st0;
  assign st1 = start_drv && (sel == 1);
  assign st0 = start_drv && (sel == 0);

  function automatic logic fdut(input logic [2:0] v);
    return v[0] ^ v[2];
  endfunction

  // Registered-DUT models: response lags the applied vector by one cycle.
  logic lag1, lag0;
  always @(posedge CK) begin
    lag1 <= fdut(n1);
    lag0 <= fdut(n0);
  end

  assign dout1 = (mode1 == 0) ? fdut(n1) : (mode1 == 1) ? lag1 : 1'b1;
  assign dout0 = lag0;

  vector_sweep_ctrl #(.N_W(3), .OUT_W(1), .SETTLE(1)) u_dut1 (
    .CK(CK), .reset(reset), .start(st1), .busy(busy1), .done(done1),
    .N(n1), .dut_out(dout1), .rec_valid(valid1), .rec_ready(ready_drv),
    .rec_vec(vec1), .rec_out(out1), .rec_count(cnt1)
`ifdef SWEEP_SIG_EN
    , .sig(sig1)
`endif
  );

  vector_sweep_ctrl #(.N_W(3), .OUT_W(1), .SETTLE(0)) u_dut0 (
    .CK(CK), .reset(reset), .start(st0), .busy(busy0), .done(done0),
    .N(n0), .dut_out(dout0), .rec_valid(valid0), .rec_ready(ready_drv),
    .rec_vec(vec0), .rec_out(out0), .rec_count(cnt0)
`ifdef SWEEP_SIG_EN
    , .sig(sig0)
`endif
  );

  // Selected-instance view
  logic       w_busy, w_done, w_valid, w_out;
  logic [2:0] w_n, w_vec;
  logic [3:0] w_cnt;
  assign w_busy  = (sel == 1) ? busy1  : busy0;
  assign w_done  = (sel == 1) ? done1  : done0;
  assign w_valid = (sel == 1) ? valid1 : valid0;
  assign w_out   = (sel == 1) ? out1   : out0;
  assign w_n     = (sel == 1) ? n1     : n0;
  assign w_vec   = (sel == 1) ? vec1   : vec0;
  assign w_cnt   = (sel == 1) ? cnt1   : cnt0;

  typedef struct {
    logic [2:0] vec;
    logic       out;      // combinational DUT response
    logic       out_lag;  // response seen through a one-cycle-late DUT with SETTLE=0
  } vec_t;
  typedef struct {
    logic [2:0] vec;
    logic       out;
  } rec_t;

  vec_t tbl[8];
  rec_t sb[$];
  rec_t e;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted record must match the next expected one.
  always @(negedge CK) begin
    if (reset && w_valid && ready_drv) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_record actual vec=%0d required none", w_vec);
      end else begin
        e = sb.pop_front();
        chk("rec_vec", {29'd0, w_vec}, {29'd0, e.vec});
        chk("rec_out", {31'd0, w_out}, {31'd0, e.out});
      end
    end
  end

  // kind: 0 = combinational response, 1 = lagged response, 2 = constant 1
  task automatic push_exp(input int kind);
    rec_t r;
    for (int i = 0; i < 8; i++) begin
      r.vec = tbl[i].vec;
      r.out = (kind == 0) ? tbl[i].out : (kind == 1) ? tbl[i].out_lag : 1'b1;
      sb.push_back(r);
    end
  endtask

  task automatic run_sweep(input int stall_vec, input int stall_n, input bit poke,
                           input int exp_cyc);
    int cyc;
    bit stalled, p2, p7;
    stalled = 0; p2 = 0; p7 = 0;
    @(posedge CK); #1 start_drv = 1'b1; ready_drv = 1'b1;
    @(posedge CK); #1 start_drv = 1'b0;
    cyc = 1;
    chk("busy_after_start", {31'd0, w_busy}, 32'd1);
    chk("n_after_start", {29'd0, w_n}, 32'd0);
    chk("count_after_start", {28'd0, w_cnt}, 32'd0);
    while (!w_done && cyc < 200) begin
      if (stall_n > 0 && !stalled && w_valid && w_vec == stall_vec[2:0]) begin
        stalled   = 1;
        ready_drv = 1'b0;
        for (int i = 0; i < stall_n; i++) begin
          @(posedge CK); #1 cyc++;
          chk("stall_valid", {31'd0, w_valid}, 32'd1);
          chk("stall_vec", {29'd0, w_vec}, stall_vec);
          chk("stall_n", {29'd0, w_n}, stall_vec);
          chk("stall_out", {31'd0, w_out}, {31'd0, tbl[stall_vec].out});
        end
        ready_drv = 1'b1;
      end else begin
        if (poke && w_valid && w_vec == 3'd2 && !p2) begin
          p2 = 1; start_drv = 1'b1;
        end else if (poke && w_valid && w_vec == 3'd7 && !p7) begin
          p7 = 1; start_drv = 1'b1;
        end else begin
          start_drv = 1'b0;
        end
        @(posedge CK); #1 cyc++;
      end
    end
    chk("sweep_cycles", cyc, exp_cyc);
    chk("done_count", {28'd0, w_cnt}, 32'd8);
    chk("busy_in_done", {31'd0, w_busy}, 32'd1);
    start_drv = poke;
    @(posedge CK); #1 start_drv = 1'b0;
    chk("done_one_cycle", {31'd0, w_done}, 32'd0);
    chk("idle_after_done", {31'd0, w_busy}, 32'd0);
    chk("records_left", sb.size(), 32'd0);
  endtask

  initial begin
    int waitc;
    for (int i = 0; i < 8; i++) begin
      tbl[i].vec     = 3'(i);
      tbl[i].out     = fdut(3'(i));
      tbl[i].out_lag = fdut(3'(i - 1));  // vector 0 follows 7 or reset: both give 0
    end

    sel = 1; mode1 = 0; start_drv = 0; ready_drv = 0; reset = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_valid", {31'd0, valid1}, 32'd0);
    chk("rst_n", {29'd0, n1}, 32'd0);
    chk("rst_count", {28'd0, cnt1}, 32'd0);
    reset = 1'b1;

    // Basic sweep: 8*(1+2)+1 = 25 cycles
    push_exp(0);
    run_sweep(-1, 0, 0, 25);

    // Four stall cycles on vector 3
    push_exp(0);
    run_sweep(3, 4, 0, 29);

    // start pulsed at vectors 2, 7 and in the done cycle: all ignored
    push_exp(0);
    run_sweep(-1, 0, 1, 25);
    repeat (3) @(posedge CK);
    #1 chk("no_restart", {31'd0, busy1}, 32'd0);
    push_exp(0);
    run_sweep(-1, 0, 0, 25);

    // Constant-1 response
    mode1 = 2;
    push_exp(2);
    run_sweep(-1, 0, 0, 25);
`ifdef SWEEP_SIG_EN
    chk("sig_const1", {16'd0, sig1}, 32'h00FF);
`endif

    // SETTLE=0 with a one-cycle-late DUT: previous vector's response
    sel = 0;
    push_exp(1);
    run_sweep(-1, 0, 0, 17);

    // Same late DUT with SETTLE=1: correct responses
    sel = 1; mode1 = 1;
    push_exp(1 - 1);
    run_sweep(-1, 0, 0, 25);

    // Reset during SETTLE of vector 5
    mode1 = 0;
    push_exp(0);
    @(posedge CK); #1 start_drv = 1'b1; ready_drv = 1'b1;
    @(posedge CK); #1 start_drv = 1'b0;
    waitc = 0;
    while (!(busy1 && n1 == 3'd5 && !valid1) && waitc < 100) begin
      @(posedge CK); #1 waitc++;
    end
    chk("reach_vec5_timeout", {31'd0, (waitc < 100)}, 32'd1);
    chk("vec4_held", {29'd0, vec1}, 32'd4);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_done", {31'd0, done1}, 32'd0);
    chk("arst_n", {29'd0, n1}, 32'd0);
    chk("arst_valid", {31'd0, valid1}, 32'd0);
    chk("arst_vec", {29'd0, vec1}, 32'd0);
    chk("arst_out", {31'd0, out1}, 32'd0);
    chk("arst_count", {28'd0, cnt1}, 32'd0);
`ifdef SWEEP_SIG_EN
    chk("arst_sig", {16'd0, sig1}, 32'd0);
`endif
    chk("arst_records_before", sb.size(), 32'd3);
    sb.delete();
    @(posedge CK); #1 reset = 1'b1;
    repeat (4) begin
      @(posedge CK); #1;
      chk("post_rst_idle", {31'd0, busy1}, 32'd0);
      chk("post_rst_done", {31'd0, done1}, 32'd0);
      chk("post_rst_valid", {31'd0, valid1}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
